// File: rtl/ham_pkg.sv
// Shared constants and elaboration-time helpers for the Hamming SECDED codec.
package ham_pkg;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SEC  = 2'b01;
    localparam logic [1:0] ERR_DED  = 2'b10;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int ham_p(input int data_w);
        int p;
        p = 0;
        for (int i = 1; i < 8; i++) begin
            if (p == 0 && (1 << i) >= data_w + i + 1) begin
                p = i;
            end
        end
        return p;
    endfunction

    function automatic logic ham_is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Hamming position of data bit idx: the idx-th non-power-of-two position >= 3.
    function automatic int ham_data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 128; p++) begin
            if (!ham_is_pow2(p) && pos == 0) begin
                if (cnt == idx) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ham_syndrome.sv
// Combinational Hamming helper: check bits from raw data, syndrome and overall
// parity from a full codeword.
module ham_syndrome
    import ham_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int P      = ham_p(DATA_W),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CODE_W-1:0] code,
    output logic [P-1:0]      check,
    output logic [P-1:0]      syn,
    output logic              par_q
);

    function automatic logic [DATA_W-1:0] check_mask(input int k);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (((ham_data_pos(i) >> k) & 1) != 0) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    for (genvar k = 0; k < P; k++) begin : g_chk
        localparam logic [DATA_W-1:0] MASK = check_mask(k);
        assign check[k] = ^(data & MASK);
    end

    always_comb begin
        syn = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                syn = syn ^ P'(i);
            end
        end
    end

    assign par_q = ^code;

endmodule

// File: rtl/ham_secded_pipe.sv
// Two-stage pipelined Hamming SECDED encoder/decoder with per-word mode,
// valid/ready flow control and saturating error counters.
module ham_secded_pipe
    import ham_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int P      = ham_p(DATA_W),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic [1:0]        out_err,
    output logic [15:0]       sec_cnt,
    output logic [15:0]       ded_cnt,
    input  logic              cnt_clr
);

    localparam logic [P:0] CODE_W_EXT = (P + 1)'(CODE_W);

    logic [P-1:0]      chk;
    logic [P-1:0]      syn;
    logic              par_q;
    logic [CODE_W-1:1] enc_body;
    logic [CODE_W-1:0] enc_word;

    logic              s1_valid;
    logic              s1_mode;
    logic [CODE_W-1:0] s1_word;
    logic [P-1:0]      s1_syn;
    logic              s1_q;

    logic              s1_adv;
    logic              s2_adv;
    logic              in_fire;
    logic              out_fire;

    logic [CODE_W-1:0] fix_word;
    logic [1:0]        fix_err;
    logic [DATA_W-1:0] dec_data;
    logic [CODE_W-1:0] nxt_data;
    logic [1:0]        nxt_err;

    ham_syndrome #(.DATA_W(DATA_W)) u_syn (
        .data  (in_data[DATA_W-1:0]),
        .code  (in_data),
        .check (chk),
        .syn   (syn),
        .par_q (par_q)
    );

    // Scatter data into non-power-of-two positions and gather it back out.
    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        localparam int POS = ham_data_pos(i);
        assign enc_body[POS] = in_data[i];
        assign dec_data[i]   = fix_word[POS];
    end

    for (genvar k = 0; k < P; k++) begin : g_chk
        assign enc_body[2**k] = chk[k];
    end

    assign enc_word = {enc_body, ^enc_body};

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s2_adv || !s1_valid;
    assign in_ready = !rst && s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_ENC;
            s1_word  <= '0;
            s1_syn   <= '0;
            s1_q     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_mode <= in_mode;
                s1_word <= (in_mode == MODE_DEC) ? in_data : enc_word;
                s1_syn  <= syn;
                s1_q    <= par_q;
            end
        end
    end

    // Odd parity means one flip (S names it, S=0 means bit 0); even parity
    // with nonzero S, or S outside the codeword, is uncorrectable.
    always_comb begin
        fix_word = s1_word;
        fix_err  = ERR_NONE;
        if (s1_q) begin
            if ({1'b0, s1_syn} < CODE_W_EXT) begin
                fix_word = s1_word ^ (CODE_W'(1) << s1_syn);
                fix_err  = ERR_SEC;
            end else begin
                fix_err = ERR_DED;
            end
        end else if (s1_syn != '0) begin
            fix_err = ERR_DED;
        end
    end

    always_comb begin
        nxt_data = s1_word;
        nxt_err  = ERR_NONE;
        if (s1_mode == MODE_DEC) begin
            nxt_data = {{(CODE_W - DATA_W){1'b0}}, dec_data};
            nxt_err  = fix_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= ERR_NONE;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= nxt_data;
                out_err  <= nxt_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (out_fire) begin
            if (out_err == ERR_SEC && sec_cnt != 16'hFFFF) begin
                sec_cnt <= sec_cnt + 16'd1;
            end
            if (out_err == ERR_DED && ded_cnt != 16'hFFFF) begin
                ded_cnt <= ded_cnt + 16'd1;
            end
        end
    end

endmodule
